// File: rtl/core_run_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_run_ctrl_if : switch/button and core-side signals of the run sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
interface core_run_ctrl_if #(
  parameter int PcBit = 32
);
  logic [1:0]       mode;
  logic             step_btn;
  logic             resume;
  logic             bp_en;
  logic [PcBit-1:0] bp_addr;
  logic [PcBit-1:0] pc;
  logic             core_halt;
  logic             core_en;
  logic [1:0]       state;
  logic             bp_hit;

  modport master (
    output mode, step_btn, resume, bp_en, bp_addr, pc, core_halt,
    input  core_en, state, bp_hit
  );

  modport slave (
    input  mode, step_btn, resume, bp_en, bp_addr, pc, core_halt,
    output core_en, state, bp_hit
  );
endinterface
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_run_ctrl : clock-enable sequencer (stop/step/slow/fast, breakpoint, halt)
// Revision 1.0
// ----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int DivMax = 50_000_000,
  parameter int PcBit  = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  core_run_ctrl_if.slave bus
);

  localparam int DivW = (DivMax > 1) ? $clog2(DivMax) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DivMax - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BREAK  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic            core_en_q, core_en_d;
  logic            bp_hit_q, bp_hit_d;
  logic [DivW-1:0] div_q, div_d;
  logic            skip_q, skip_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;

  logic [PcBit-1:0] pc_w;
  logic [PcBit-1:0] bp_addr_w;
  logic             step_edge;
  logic             gate_open;
  logic             match;
  logic             halt_now;
  logic             cand;

  assign pc_w      = bus.pc;
  assign bp_addr_w = bus.bp_addr;
  assign step_edge = sync2_q & ~prev_q;
  // Never issue back-to-back pulses, so pc/core_halt are settled when sampled.
  assign gate_open = ~core_en_q;
  assign match     = bus.bp_en & (pc_w == bp_addr_w) & ~skip_q;
  assign halt_now  = bus.core_halt & ~core_en_q;

  always_comb begin
    state_d   = state_q;
    core_en_d = 1'b0;
    div_d     = div_q;
    skip_d    = skip_q;
    cand      = 1'b0;
    sync1_d   = bus.step_btn;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.mode == 2'b01 && step_edge) begin
          cand = gate_open;
        end else if (bus.mode[1]) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end
      ST_RUN: begin
        if (!bus.mode[1]) begin
          state_d = ST_IDLE;
        end else if (bus.mode[0]) begin
          cand = gate_open;
        end else if (div_q == DivLast) begin
          div_d = '0;
          cand  = gate_open;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      ST_BREAK: begin
        if (bus.resume) begin
          skip_d  = 1'b1;
          div_d   = '0;
          state_d = bus.mode[1] ? ST_RUN : ST_IDLE;
        end
      end
      default: ;
    endcase

    if (cand) begin
      if (match) begin
        state_d = ST_BREAK;
      end else begin
        core_en_d = 1'b1;
        skip_d    = 1'b0;
      end
    end

    // Halt wins over any step, candidate or resume in the same cycle.
    if (halt_now) begin
      state_d   = ST_HALTED;
      core_en_d = 1'b0;
      skip_d    = skip_q;
    end

    bp_hit_d = (state_d == ST_BREAK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      core_en_q <= 1'b0;
      bp_hit_q  <= 1'b0;
      div_q     <= '0;
      skip_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_en_q <= core_en_d;
      bp_hit_q  <= bp_hit_d;
      div_q     <= div_d;
      skip_q    <= skip_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
    end
  end

  assign bus.core_en = core_en_q;
  assign bus.state   = state_q;
  assign bus.bp_hit  = bp_hit_q;

endmodule
`default_nettype wire

// File: doc/core_run_ctrl.md
# core_run_ctrl

Execution sequencer for the single-cycle core. It replaces the free-running divided core clock with a clock-enable scheme on the board clock. It generates one-cycle `core_en` advance pulses in stop, single-step, slow-run and fast-run modes, stops on a PC breakpoint, and latches the core's halt. It sits between the switch/button inputs and the core's `en` input; the cycle/jump/branch counters keep counting on `core_en` unchanged.

## Interface
- `DivMax`, default 50_000_000, board-clock cycles between advances in slow-run (500 ms at 100 MHz); must be ≥ 2.
- `PcBit`, default 32, width of `pc` and `bp_addr`.

- `clk`  in  1  board clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  2  00 stop, 01 step, 10 slow-run, 11 fast-run; level from switches, asynchronous to nothing (already on `clk` domain).
- `step_btn`  in  1  raw step button level; synchronized internally.
- `resume`  in  1  one-cycle pulse; leaves BREAK.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  PcBit  breakpoint address.
- `pc`  in  PcBit  core's current PC (changes only after a `core_en` cycle).
- `core_halt`  in  1  core halt indication.
- `core_en`  out  1  registered; one-cycle advance pulse to the core.
- `state`  out  2  00 IDLE, 01 RUN, 10 BREAK, 11 HALTED.
- `bp_hit`  out  1  registered; high while in BREAK.

## Operation
- Reset values: state IDLE, `core_en` 0, `bp_hit` 0, divider 0, skip flag 0, synchronizer and edge flops 0.
- Step detection: 2-flop synchronizer on `step_btn` plus a previous-value flop. `step_edge` = synchronized value 1 and previous value 0.
- Issue gate: candidate advance is blocked when `core_en` is currently 1. Consequently no two consecutive `core_en` cycles ever occur, and `pc`/`core_halt` are always settled when sampled.
- Breakpoint match = `bp_en` & (`pc` == `bp_addr`) & !skip.
- IDLE:
  - mode 01 and `step_edge`: if match, go to BREAK; else pulse `core_en`.
  - mode 1x: go to RUN with divider cleared.
  - mode 00: no action.
- RUN:
  - mode 0x: go to IDLE with no pulse.
  - mode 11: candidate every cycle the gate allows.
  - mode 10: divider counts 0..DivMax-1; the candidate occurs at DivMax-1, then the divider returns to 0.
  - A candidate with match goes to BREAK with no pulse; otherwise it pulses `core_en`.
- BREAK: `bp_hit`=1, no pulses. On `resume`, set skip, go to IDLE if mode 0x, else RUN (divider cleared). Mode changes alone do not leave BREAK.
- Skip flag: cleared by the first `core_en` pulse after being set, or by `rst`. It allows exactly one advance past the breakpoint address.
- HALTED: entered from any state in the cycle after `core_halt` is sampled 1 while `core_en` is 0. `core_halt` takes precedence over a simultaneous step, candidate or resume, and no pulse is issued. HALTED is left only by `rst`.
- `resume` outside BREAK is ignored. A step edge in any mode other than 01, or outside IDLE, is ignored and not queued.

## Timing
- Step: `step_btn` first sampled high at edge k leads to `core_en` high during the cycle after edge k+2, for exactly one cycle.
- Fast-run: `core_en` pattern is 1,0,1,0…; the first pulse comes in the second cycle after entering RUN.
- Slow-run: pulses are DivMax cycles apart.
- Breakpoint: when match is true in a candidate cycle, `bp_hit`/`state`=BREAK become visible in the next cycle and no pulse is issued for that candidate.
- Halt: `state`=HALTED is visible one cycle after `core_halt` is sampled.
- `rst` asserted mid-run: the next cycle shows all reset values, including a `core_en` pulse in flight dropped to 0.

## Test plan
- Reset, mode 01, press `step_btn` for 10 cycles → exactly one `core_en` pulse, at the 3rd edge after the press; press again after release → second pulse.
- Mode 11, 20 cycles, no bp → `core_en` alternates 1/0, 10 pulses; switch to 00 → IDLE, pulses stop next cycle.
- Mode 10, DivMax=4 → pulses every 4 cycles; drop to mode 00 mid-count then return to 10 → divider restarts at 0.
- Mode 11, `bp_en`=1, `bp_addr`=0x0000_0010, pc model advancing by 4 per pulse from 0 → 4 pulses, then BREAK with `bp_hit`=1 and pc 0x10. `resume` → one pulse past 0x10, running continues; a later return to 0x10 breaks again.
- Mode 11, assert `core_halt` together with a candidate cycle → no pulse, HALTED; `resume` and step ignored; `rst` → IDLE.
- Mode 01, `step_edge` and `core_halt` in the same cycle → no pulse, HALTED.
